// File: rtl/stash_wb_sequencer.sv
// Path-writeback sequencer: walks the stash scan table, and turns each returned
// stash entry into a tagged stash read command (level, slot, dummy, last).
module stash_wb_sequencer #(
    parameter int ORAMZ = 4,
    parameter int ORAML = 10,
    parameter int SEAWidth = 8,
    parameter int STAWidth = 6,
    parameter int BktAWidth = 4,
    parameter logic [SEAWidth-1:0] SNULL = {SEAWidth{1'b1}},
    parameter int MaxOutstanding = 4,
    localparam int SlotWidth = (ORAMZ > 1) ? $clog2(ORAMZ) : 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    output logic                 Busy,
    output logic                 Done,
    output logic [STAWidth-1:0]  OutDMAAddr,
    output logic                 OutDMAValid,
    input  logic [SEAWidth-1:0]  InDMASAddr,
    input  logic                 InDMASValid,
    output logic                 InDMASReady,
    output logic [SEAWidth-1:0]  StashRdSAddr,
    output logic                 StashRdDummy,
    output logic [BktAWidth-1:0] StashRdLevel,
    output logic [SlotWidth-1:0] StashRdSlot,
    output logic                 StashRdLast,
    output logic                 StashRdValid,
    input  logic                 StashRdReady,
    output logic [1:0]           DebugState
);

    localparam int BlocksOnPath = ORAMZ * (ORAML + 1);
    localparam int OutWidth = $clog2(MaxOutstanding + 1);

    localparam logic [STAWidth-1:0]  BlocksLimit = STAWidth'(BlocksOnPath);
    localparam logic [STAWidth-1:0]  LastIndex   = STAWidth'(BlocksOnPath - 1);
    localparam logic [STAWidth-1:0]  StaOne      = STAWidth'(1);
    localparam logic [OutWidth-1:0]  OutLimit    = OutWidth'(MaxOutstanding);
    localparam logic [OutWidth-1:0]  OutOne      = OutWidth'(1);
    localparam logic [SlotWidth-1:0] SlotLast    = SlotWidth'(ORAMZ - 1);
    localparam logic [SlotWidth-1:0] SlotOne     = SlotWidth'(1);
    localparam logic [BktAWidth-1:0] LvlOne      = BktAWidth'(1);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1,
        StDone   = 2'd2
    } state_t;

    state_t state;
    state_t stateNext;

    logic [STAWidth-1:0]  issueCnt;
    logic [STAWidth-1:0]  issueCntNext;
    logic [STAWidth-1:0]  consCnt;
    logic [STAWidth-1:0]  consCntNext;
    logic [OutWidth-1:0]  outstanding;
    logic [OutWidth-1:0]  outstandingNext;
    logic [SlotWidth-1:0] slotCnt;
    logic [SlotWidth-1:0] slotNext;
    logic [BktAWidth-1:0] levelCnt;
    logic [BktAWidth-1:0] levelNext;
    logic                 dmaValid;
    logic                 issueNext;

    logic isActive;
    logic handshake;
    logic lastSlot;

    // Handshakes: a command transfers on a cycle where StashRdValid and
    // StashRdReady are both high; valid never waits on ready and, once raised,
    // stays up with stable payload until taken because the FIFO head only moves
    // on a pop. The same cycle pops the scan-table FIFO (InDMASReady). The DMA
    // read port has no ready: every OutDMAValid cycle is one accepted read.
    assign isActive  = (state == StActive);
    assign handshake = isActive & InDMASValid & StashRdReady;
    assign lastSlot  = (consCnt == LastIndex);

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= StIdle;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            StIdle:   if (Start) stateNext = StActive;
            StActive: if (handshake && lastSlot) stateNext = StDone;
            StDone:   stateNext = StIdle;
            default:  stateNext = StIdle;
        endcase
    end

    // Counters only run while ACTIVE; outside it they sit at zero so a new
    // Start always begins at address 0, level 0, slot 0.
    always_comb begin
        issueCntNext    = issueCnt;
        consCntNext     = consCnt;
        outstandingNext = outstanding;
        slotNext        = slotCnt;
        levelNext       = levelCnt;
        if (!isActive) begin
            issueCntNext    = '0;
            consCntNext     = '0;
            outstandingNext = '0;
            slotNext        = '0;
            levelNext       = '0;
        end else begin
            if (dmaValid) begin
                issueCntNext = issueCnt + StaOne;
            end
            if (handshake) begin
                consCntNext = consCnt + StaOne;
                if (slotCnt == SlotLast) begin
                    slotNext  = '0;
                    levelNext = levelCnt + LvlOne;
                end else begin
                    slotNext = slotCnt + SlotOne;
                end
            end
            case ({dmaValid, handshake})
                2'b10:   outstandingNext = outstanding + OutOne;
                2'b01:   outstandingNext = outstanding - OutOne;
                default: outstandingNext = outstanding;
            endcase
        end
        // Look ahead one cycle so the read strobe leaves a flop.
        issueNext = (stateNext == StActive) && (issueCntNext < BlocksLimit) &&
                    (outstandingNext < OutLimit);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            issueCnt    <= '0;
            consCnt     <= '0;
            outstanding <= '0;
            slotCnt     <= '0;
            levelCnt    <= '0;
            dmaValid    <= 1'b0;
        end else begin
            issueCnt    <= issueCntNext;
            consCnt     <= consCntNext;
            outstanding <= outstandingNext;
            slotCnt     <= slotNext;
            levelCnt    <= levelNext;
            dmaValid    <= issueNext;
        end
    end

    always_comb begin
        Busy         = isActive;
        Done         = (state == StDone);
        OutDMAValid  = dmaValid;
        OutDMAAddr   = issueCnt;
        StashRdValid = isActive & InDMASValid;
        InDMASReady  = isActive & StashRdReady;
        StashRdSAddr = InDMASAddr;
        StashRdDummy = (InDMASAddr == SNULL);
        StashRdLevel = levelCnt;
        StashRdSlot  = slotCnt;
        StashRdLast  = isActive & InDMASValid & lastSlot;
        DebugState   = state;
    end

endmodule

// File: tb/tb_stash_wb_sequencer.sv
// Directed bench for stash_wb_sequencer on a 12-slot path (Z=4, L=2), with a
// small scan-table model that returns each read one cycle after it is issued.
module tb_stash_wb_sequencer;

    localparam int Blocks = 12;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Start;
    logic       Busy;
    logic       Done;
    logic [5:0] OutDMAAddr;
    logic       OutDMAValid;
    logic [7:0] InDMASAddr;
    logic       InDMASValid;
    logic       InDMASReady;
    logic [7:0] StashRdSAddr;
    logic       StashRdDummy;
    logic [3:0] StashRdLevel;
    logic [1:0] StashRdSlot;
    logic       StashRdLast;
    logic       StashRdValid;
    logic       StashRdReady;
    logic [1:0] DebugState;

    stash_wb_sequencer #(
        .ORAMZ(4), .ORAML(2), .SEAWidth(8), .STAWidth(6), .BktAWidth(4),
        .MaxOutstanding(4)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Busy(Busy), .Done(Done),
        .OutDMAAddr(OutDMAAddr), .OutDMAValid(OutDMAValid),
        .InDMASAddr(InDMASAddr), .InDMASValid(InDMASValid), .InDMASReady(InDMASReady),
        .StashRdSAddr(StashRdSAddr), .StashRdDummy(StashRdDummy),
        .StashRdLevel(StashRdLevel), .StashRdSlot(StashRdSlot),
        .StashRdLast(StashRdLast), .StashRdValid(StashRdValid),
        .StashRdReady(StashRdReady), .DebugState(DebugState)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int          readyMode;     // 0 always, 1 alternating, 2 never, 3 random
        logic [11:0] nullMask;      // entries returned as SNULL
        int          startAgainAt;  // tick to re-pulse Start, -1 none
        int          stallTicks;    // ticks of Ready=0 right after Start
        int          expDummies;
        int          expDoneLat;    // ticks from Start sample to Done, -1 skip
    } vec_t;

    vec_t vecs[6];

    int assertCnt = 0;
    int failCnt = 0;
    int cyc = 0;
    int issCnt, hsCnt, outst, maxOutst, doneCnt, dummyCnt, doneTick, startTick;
    int readyMode = 2;

    logic [7:0]  pathData[Blocks];
    logic [7:0]  fifo_q[$];
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        assertCnt++;
        if (got !== want) begin
            failCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic drive_inputs();
        InDMASValid = (fifo_q.size() != 0);
        InDMASAddr  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        case (readyMode)
            0:       StashRdReady = 1'b1;
            1:       StashRdReady = (cyc % 2 == 0);
            2:       StashRdReady = 1'b0;
            default: StashRdReady = 1'($urandom_range(0, 1));
        endcase
    endtask

    // One clock: sample settled outputs at negedge, then update the model and
    // drive new inputs just after the posedge.
    task automatic tick();
        logic       iss;
        logic       hs;
        logic [5:0] addr;
        logic [15:0] expWord;
        @(negedge Clock);
        iss  = OutDMAValid && Reset;
        hs   = StashRdValid && StashRdReady && Reset;
        addr = OutDMAAddr;
        if (Reset) begin
            if (iss) check("issue_addr", 32'(addr), 32'(issCnt));
            if (StashRdValid) check("last_flag", 32'(StashRdLast), 32'(hsCnt == Blocks - 1));
            if (hs) begin
                if (exp_q.size() == 0) begin
                    check("extra_handshake", 32'(1), 32'(0));
                end else begin
                    expWord = exp_q.pop_front();
                    check("command", 32'({StashRdLast, StashRdDummy, StashRdLevel,
                                          StashRdSlot, StashRdSAddr}), 32'(expWord));
                end
                if (StashRdDummy) dummyCnt++;
            end
            if (Done) begin
                doneCnt++;
                doneTick = cyc;
                check("busy_low_at_done", 32'(Busy), 32'(0));
            end
        end
        @(posedge Clock);
        #1;
        if (hs && fifo_q.size() != 0) void'(fifo_q.pop_front());
        if (iss) begin
            fifo_q.push_back(pathData[int'(addr) % Blocks]);
            issCnt++;
        end
        if (hs) hsCnt++;
        if (iss || hs) begin
            outst = outst + int'(iss) - int'(hs);
            if (outst > maxOutst) maxOutst = outst;
            check("outstanding_range", 32'(outst >= 0 && outst <= 4), 32'(1));
        end
        Start = 1'b0;
        cyc++;
        drive_inputs();
    endtask

    task automatic prep(input vec_t v);
        exp_q.delete();
        for (int n = 0; n < Blocks; n++) begin
            pathData[n] = v.nullMask[n] ? 8'hFF : 8'(16 + n);
            exp_q.push_back({(n == Blocks - 1), v.nullMask[n], 4'(n / 4), 2'(n % 4), pathData[n]});
        end
        issCnt = 0; hsCnt = 0; outst = 0; maxOutst = 0;
        doneCnt = 0; dummyCnt = 0; doneTick = -1;
    endtask

    task automatic run_vector(input vec_t v, input int idx);
        prep(v);
        readyMode = (v.stallTicks > 0) ? 2 : v.readyMode;
        drive_inputs();
        Start = 1'b1;
        tick();
        startTick = cyc;
        check($sformatf("v%0d_busy_after_start", idx), 32'(Busy), 32'(1));
        check($sformatf("v%0d_first_issue", idx), 32'({OutDMAValid, OutDMAAddr}), 32'({1'b1, 6'd0}));
        if (v.stallTicks > 0) begin
            repeat (v.stallTicks) tick();
            check($sformatf("v%0d_stall_issues", idx), 32'(issCnt), 32'(4));
            check($sformatf("v%0d_stall_dma_low", idx), 32'(OutDMAValid), 32'(0));
            readyMode = v.readyMode;
            drive_inputs();
        end
        for (int t = 0; t < 200 && doneCnt == 0; t++) begin
            if (t == v.startAgainAt) Start = 1'b1;
            tick();
        end
        if (doneCnt == 0) check($sformatf("v%0d_done_timeout", idx), 32'(0), 32'(1));
        repeat (3) tick();
        check($sformatf("v%0d_done_count", idx), 32'(doneCnt), 32'(1));
        check($sformatf("v%0d_issue_count", idx), 32'(issCnt), 32'(Blocks));
        check($sformatf("v%0d_consume_count", idx), 32'(hsCnt), 32'(Blocks));
        check($sformatf("v%0d_exp_left", idx), 32'(exp_q.size()), 32'(0));
        check($sformatf("v%0d_dummies", idx), 32'(dummyCnt), 32'(v.expDummies));
        check($sformatf("v%0d_max_outstanding", idx), 32'(maxOutst <= 4), 32'(1));
        check($sformatf("v%0d_idle_after", idx), 32'({Busy, Done, OutDMAValid, DebugState}), 32'(0));
        if (v.expDoneLat >= 0)
            check($sformatf("v%0d_done_latency", idx), 32'(doneTick - startTick), 32'(v.expDoneLat));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(Busy), 32'(0));
        check({tag, "_done"}, 32'(Done), 32'(0));
        check({tag, "_dma"}, 32'({OutDMAValid, OutDMAAddr}), 32'(0));
        check({tag, "_rdvalid"}, 32'(StashRdValid), 32'(0));
        check({tag, "_fifo_ready"}, 32'(InDMASReady), 32'(0));
        check({tag, "_state"}, 32'(DebugState), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vecs[0] = '{0, 12'h000, -1, 0, 0, 13};
        vecs[1] = '{0, 12'h088, -1, 0, 2, 13};
        vecs[2] = '{1, 12'h000, -1, 0, 0, -1};
        vecs[3] = '{0, 12'h000,  5, 0, 0, 13};
        vecs[4] = '{0, 12'h000, -1, 20, 0, -1};
        vecs[5] = '{3, 12'h801, -1, 0, 2, -1};

        // Clock/reset
        Reset = 1'b0; Start = 1'b0; InDMASValid = 1'b0; InDMASAddr = 8'h00; StashRdReady = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        Reset = 1'b1;
        readyMode = 0;
        drive_inputs();

        // FIFO data presented while idle must be neither consumed nor popped
        InDMASValid = 1'b1;
        InDMASAddr  = 8'h55;
        #1;
        check("idle_no_pop", 32'(InDMASReady), 32'(0));
        check("idle_no_cmd", 32'(StashRdValid), 32'(0));
        tick();
        check("idle_state", 32'({Busy, DebugState}), 32'(0));

        for (int i = 0; i < 6; i++) run_vector(vecs[i], i);

        // Reset in the middle of a path, then a clean restart
        prep(vecs[0]);
        readyMode = 0;
        drive_inputs();
        Start = 1'b1;
        tick();
        for (int t = 0; t < 50 && hsCnt < 6; t++) tick();
        check("mid_hs_count", 32'(hsCnt), 32'(6));
        Reset = 1'b0;
        tick();
        check_reset_outputs("midreset");
        fifo_q.delete();
        Reset = 1'b1;
        drive_inputs();
        tick();
        run_vector(vecs[0], 6);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule

// File: doc/stash_wb_sequencer.md
Name: stash_wb_sequencer

Overview:
- Path-writeback sequencer directly downstream of the O(1) stash scan table.
- On Start it walks scan-table addresses 0..BlocksOnPath-1 on the scan table's DMA read port and consumes the stash-entry addresses returned from the scan table's output FIFO.
- It emits one stash read command per path slot, tagged with bucket level, slot-in-bucket and dummy flag (entry == SNULL).
- Credit flow control bounds in-flight scan-table reads so the scan-table FIFO can never overflow.

Parameters:
- ORAMZ, 4, blocks per bucket.
- ORAML, 10, leaf width; path has ORAML+1 buckets.
- SEAWidth, 8, stash entry address width.
- STAWidth, 6, scan-table address width; must hold ORAMZ*(ORAML+1).
- BktAWidth, 4, bucket level index width; must hold ORAML.
- SNULL, 2^SEAWidth-1, null stash entry marker.
- MaxOutstanding, 4, max scan-table reads issued but not yet consumed; 1..BlocksOnPath.
- Derived: BlocksOnPath = ORAMZ*(ORAML+1).

Ports:
- Clock  in  1  system clock.
- Reset  in  1  one clock; reset is synchronous and active-low (Reset=0 resets).
- Start  in  1  1-cycle pulse: scan complete, begin writeback.
- Busy  out  1  high from cycle after Start until Done.
- Done  out  1  1-cycle pulse after last slot handshake.
- OutDMAAddr  out  STAWidth  scan-table read address.
- OutDMAValid  out  1  read strobe; no ready; scan table always accepts.
- InDMASAddr  in  SEAWidth  stash entry from scan-table FIFO.
- InDMASValid  in  1  FIFO output valid.
- InDMASReady  out  1  pop FIFO.
- StashRdSAddr  out  SEAWidth  stash entry to read (InDMASAddr pass-through).
- StashRdDummy  out  1  InDMASAddr == SNULL; write dummy block.
- StashRdLevel  out  BktAWidth  bucket level 0 (root)..ORAML.
- StashRdSlot  out  log2(ORAMZ)  slot within bucket.
- StashRdLast  out  1  final slot of path.
- StashRdValid  out  1  command valid.
- StashRdReady  in  1  downstream accepts.

Behaviour:
- Reset values: Busy=0, Done=0, OutDMAValid=0, OutDMAAddr=0, StashRdValid=0, InDMASReady=0; all counters 0; FSM in IDLE.
- FSM:
  - IDLE: Start -> ACTIVE.
  - ACTIVE: handshake on last slot (ConsCnt==BlocksOnPath-1) -> DONE.
  - DONE: asserts Done one cycle -> IDLE.
  - Start is ignored outside IDLE.
- Issue side, registered:
  - In ACTIVE, OutDMAValid=1 when IssueCnt<BlocksOnPath and Outstanding<MaxOutstanding; OutDMAAddr=IssueCnt.
  - Each valid cycle: IssueCnt+1, Outstanding+1.
  - First issue occurs the cycle after Start; back-to-back issue allowed.
- Consume side, combinational:
  - StashRdValid = ACTIVE & InDMASValid.
  - InDMASReady = ACTIVE & StashRdReady.
  - Handshake = StashRdValid & StashRdReady. On handshake: Outstanding-1, ConsCnt+1.
  - Level/Slot are separate counters: Slot wraps ORAMZ-1 -> 0 and increments Level on wrap. No divider.
- Same-cycle issue and consume: Outstanding unchanged.
- Outstanding never exceeds MaxOutstanding and never underflows.
- Order: the scan table returns data in request order, so the n-th consumed entry corresponds to address n. Slot n maps to Level = n/ORAMZ, Slot = n%ORAMZ.
- StashRdLast = StashRdValid & ConsCnt==BlocksOnPath-1.
- Reset mid-operation (Reset=0 at any time): return to reset values next edge; in-flight FIFO data is the upstream's responsibility (flushed by its own reset).
- InDMASValid in IDLE/DONE is ignored and not popped.

Test Plan (ORAMZ=4, ORAML=2, MaxOutstanding=4, BlocksOnPath=12):
- Reset, then Start; StashRdReady=1; FIFO returns entries 0x10..0x1B one cycle after each read -> 12 reads addr 0..11, no gaps after warm-up. Commands carry Level 0,0,0,0,1..2,2; Slot 0..3 repeating. StashRdLast on the 12th only. Done pulses once. Busy falls with Done.
- StashRdReady=0 for 20 cycles after Start -> exactly 4 reads issued (addr 0..3), then OutDMAValid held low. Releasing Ready resumes issue at addr 4.
- Entries 3 and 7 return SNULL=0xFF -> StashRdDummy=1 only on slots 3 (L0 S3) and 7 (L1 S3).
- Start pulsed again while ACTIVE -> no effect: IssueCnt continues, single Done.
- Reset=0 after 6 handshakes -> next cycle all outputs 0, FSM IDLE. A new Start restarts at OutDMAAddr=0, Level 0 Slot 0.
- Alternating StashRdReady with same-cycle issue and consume -> Outstanding stays ≤4. Issue and consume counts both reach 12.
